// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants and shared types for the timing generator.
package vga_timing_pkg;

    localparam int CNT_W   = 10;
    localparam int FRAME_W = 16;

    localparam int VGA_CLK_DIV     = 4;
    localparam int VGA_H_TOTAL     = 800;
    localparam int VGA_V_TOTAL     = 525;
    localparam int VGA_H_SYNC      = 96;
    localparam int VGA_V_SYNC      = 2;
    localparam int VGA_H_ACT_START = 144;
    localparam int VGA_H_ACT_END   = 783;
    localparam int VGA_V_ACT_START = 35;
    localparam int VGA_V_ACT_END   = 514;

    typedef logic [CNT_W-1:0] cnt_t;

    // Inclusive range test used by the visible-window decode.
    function automatic logic in_window(cnt_t value, int lo, int hi);
        return (int'(value) >= lo) && (int'(value) <= hi);
    endfunction

endpackage

// File: rtl/vga_mod_counter.sv
// Mod-N counter with count enable; wrap flags the enabled edge that returns it to 0.
module vga_mod_counter #(
    parameter int MODULUS = 800,
    parameter int WIDTH   = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    assign wrap = en && (count == WIDTH'(MODULUS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v counters, zero-latency sync/window decode.
// Define VGA_FRAME_CNT_EN to build frame_tick / frame_count; otherwise both are tied to 0.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV     = VGA_CLK_DIV,
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int H_ACT_START = VGA_H_ACT_START,
    parameter int H_ACT_END   = VGA_H_ACT_END,
    parameter int V_ACT_START = VGA_V_ACT_START,
    parameter int V_ACT_END   = VGA_V_ACT_END
) (
    input  logic               clk,
    input  logic               reset,
    output logic [CNT_W-1:0]   hCount,
    output logic [CNT_W-1:0]   vCount,
    output logic               bright,
    output logic               hSync,
    output logic               vSync,
    output logic               pix_en,
    output logic               frame_tick,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic             div_last;
    logic             h_wrap;
    logic             v_wrap;

    assign div_last = (div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (div_last) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Gated so a CLK_DIV of 1 still reads pix_en=0 while reset is held.
    assign pix_en = div_last && !reset;

    vga_mod_counter #(
        .MODULUS (H_TOTAL),
        .WIDTH   (CNT_W)
    ) u_h_counter (
        .clk   (clk),
        .reset (reset),
        .en    (pix_en),
        .count (hCount),
        .wrap  (h_wrap)
    );

    vga_mod_counter #(
        .MODULUS (V_TOTAL),
        .WIDTH   (CNT_W)
    ) u_v_counter (
        .clk   (clk),
        .reset (reset),
        .en    (h_wrap),
        .count (vCount),
        .wrap  (v_wrap)
    );

    assign hSync  = (hCount >= CNT_W'(H_SYNC));
    assign vSync  = (vCount >= CNT_W'(V_SYNC));
    assign bright = in_window(hCount, H_ACT_START, H_ACT_END)
                 && in_window(vCount, V_ACT_START, V_ACT_END);

`ifdef VGA_FRAME_CNT_EN
    // v_wrap marks the edge into (0,0); registering it gives a tick in the first cycle of the new frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_tick  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_tick <= v_wrap;
            if (v_wrap) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end
`else
    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;
    assign frame_tick    = 1'b0;
    assign frame_count   = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance plus a shrunken-timing instance for whole frames.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int S_DIV = 2, S_HT = 40, S_VT = 12, S_HS = 6, S_VS = 2;
    localparam int S_HAS = 10, S_HAE = 33, S_VAS = 3, S_VAE = 9;
    localparam int F = S_DIV * S_HT * S_VT;

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        br;
        logic        pe;
        logic        ft;
        logic [15:0] fc;
    } obs_t;

    typedef struct {
        int div; int ht; int vt; int hs; int vs; int has; int hae; int vas; int vae;
    } cfg_t;

    cfg_t cfg_d = '{div: VGA_CLK_DIV, ht: VGA_H_TOTAL, vt: VGA_V_TOTAL, hs: VGA_H_SYNC,
                    vs: VGA_V_SYNC, has: VGA_H_ACT_START, hae: VGA_H_ACT_END,
                    vas: VGA_V_ACT_START, vae: VGA_V_ACT_END};
    cfg_t cfg_s = '{div: S_DIV, ht: S_HT, vt: S_VT, hs: S_HS, vs: S_VS,
                    has: S_HAS, hae: S_HAE, vas: S_VAS, vae: S_VAE};

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  d_hc, d_vc, s_hc, s_vc;
    logic        d_br, d_hs, d_vs, d_pe, d_ft, s_br, s_hs, s_vs, s_pe, s_ft;
    logic [15:0] d_fc, s_fc;
    obs_t        d_obs, s_obs, e_d, e_s;

    longint t;
    int     n_checks = 0;
    int     n_fails  = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut (
        .clk(clk), .reset(reset), .hCount(d_hc), .vCount(d_vc), .bright(d_br),
        .hSync(d_hs), .vSync(d_vs), .pix_en(d_pe), .frame_tick(d_ft), .frame_count(d_fc)
    );

    vga_timing_gen #(
        .CLK_DIV(S_DIV), .H_TOTAL(S_HT), .V_TOTAL(S_VT), .H_SYNC(S_HS), .V_SYNC(S_VS),
        .H_ACT_START(S_HAS), .H_ACT_END(S_HAE), .V_ACT_START(S_VAS), .V_ACT_END(S_VAE)
    ) dut_s (
        .clk(clk), .reset(reset), .hCount(s_hc), .vCount(s_vc), .bright(s_br),
        .hSync(s_hs), .vSync(s_vs), .pix_en(s_pe), .frame_tick(s_ft), .frame_count(s_fc)
    );

    assign d_obs = {d_hc, d_vc, d_hs, d_vs, d_br, d_pe, d_ft, d_fc};
    assign s_obs = {s_hc, s_vc, s_hs, s_vs, s_br, s_pe, s_ft, s_fc};

    // Reference: everything follows from t, the number of clk edges since reset release.
    function automatic obs_t model(cfg_t c, longint tt, logic r);
        obs_t   e;
        longint p, frames;
        int     h, v;
        p      = tt / c.div;
        h      = int'(p % c.ht);
        v      = int'((p / c.ht) % c.vt);
        frames = p / (c.ht * c.vt);
        e.h    = 10'(h);
        e.v    = 10'(v);
        e.hs   = (h >= c.hs);
        e.vs   = (v >= c.vs);
        e.br   = (h >= c.has) && (h <= c.hae) && (v >= c.vas) && (v <= c.vae);
        e.pe   = ((tt % c.div) == c.div - 1) && !r;
`ifdef VGA_FRAME_CNT_EN
        e.ft   = (frames > 0) && ((p % (c.ht * c.vt)) == 0) && ((tt % c.div) == 0) && !r;
        e.fc   = 16'(frames % 65536);
`else
        e.ft   = 1'b0;
        e.fc   = 16'd0;
`endif
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!reset) t++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        t     = 0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        t     = 0;
        repeat (3) tick();
        n_checks++;
        if (d_obs !== '0) begin n_fails++; $display("FAIL reset_default got=%h exp=0", d_obs); end
        n_checks++;
        if (s_obs !== '0) begin n_fails++; $display("FAIL reset_small got=%h exp=0", s_obs); end
    endtask

    task automatic test_first_pixels();
        logic exp_pe;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            exp_pe = (k == 4) || (k == 8);
            n_checks++;
            if (d_pe !== exp_pe) begin
                n_fails++; $display("FAIL first_pix_en clk=%0d got=%b exp=%b", k, d_pe, exp_pe);
            end
            tick();
        end
        n_checks++;
        if (d_hc !== 10'd2 || d_vc !== 10'd0) begin
            n_fails++; $display("FAIL first_counts got h=%0d v=%0d exp h=2 v=0", d_hc, d_vc);
        end
    endtask

    task automatic test_line_wrap();
        int         hs_low0 = 0, hs_low1 = 0, wraps = 0;
        logic [9:0] prev_h = 0, prev_v = 0;
        do_reset();
        for (int k = 0; k < 6400; k++) begin
            e_d = model(cfg_d, t, reset);
            e_s = model(cfg_s, t, reset);
            n_checks += 2;
            if (d_obs !== e_d) begin n_fails++; $display("FAIL line_default t=%0d got=%h exp=%h", t, d_obs, e_d); end
            if (s_obs !== e_s) begin n_fails++; $display("FAIL line_small t=%0d got=%h exp=%h", t, s_obs, e_s); end
            if (!d_hs) begin
                if (k < 3200) hs_low0++; else hs_low1++;
            end
            if (prev_h == 10'd799 && d_hc == 10'd0) begin
                wraps++;
                n_checks++;
                if (d_vc !== 10'(prev_v + 10'd1)) begin
                    n_fails++; $display("FAIL line_vwrap got v=%0d exp=%0d", d_vc, prev_v + 10'd1);
                end
            end
            prev_h = d_hc;
            prev_v = d_vc;
            tick();
        end
        n_checks++;
        if (wraps != 1) begin n_fails++; $display("FAIL line_wrap_seen got=%0d exp=1", wraps); end
        n_checks++;
        if (hs_low0 != 384 || hs_low1 != 384) begin
            n_fails++; $display("FAIL hsync_width got=%0d,%0d exp=384", hs_low0, hs_low1);
        end
    endtask

    task automatic test_frame();
        int vs_low = 0, br_hi = 0, edge_seen = 0, edge_bad = 0;
        do_reset();
        for (int k = 0; k < F; k++) begin
            e_d = model(cfg_d, t, reset);
            e_s = model(cfg_s, t, reset);
            n_checks += 2;
            if (d_obs !== e_d) begin n_fails++; $display("FAIL frame_default t=%0d got=%h exp=%h", t, d_obs, e_d); end
            if (s_obs !== e_s) begin n_fails++; $display("FAIL frame_small t=%0d got=%h exp=%h", t, s_obs, e_s); end
            if (!s_vs) vs_low++;
            if (s_br) br_hi++;
            if (s_hc == 10'(S_HAS - 1) || s_hc == 10'(S_HAE + 1)) begin
                edge_seen++;
                if (s_br) edge_bad++;
            end
            tick();
        end
        n_checks++;
        if (vs_low != S_VS * S_HT * S_DIV) begin
            n_fails++; $display("FAIL vsync_width got=%0d exp=%0d", vs_low, S_VS * S_HT * S_DIV);
        end
        n_checks++;
        if (br_hi != (S_HAE - S_HAS + 1) * (S_VAE - S_VAS + 1) * S_DIV) begin
            n_fails++; $display("FAIL bright_area got=%0d exp=%0d", br_hi,
                                (S_HAE - S_HAS + 1) * (S_VAE - S_VAS + 1) * S_DIV);
        end
        n_checks++;
        if (edge_seen == 0 || edge_bad != 0) begin
            n_fails++; $display("FAIL bright_edges got bad=%0d seen=%0d exp bad=0", edge_bad, edge_seen);
        end
    endtask

    task automatic test_two_frames();
        int   pulses = 0, high_cycles = 0;
        logic prev_ft = 1'b0;
        int   exp_n;
        do_reset();
        for (int k = 0; k < 2 * F + 2 * S_DIV; k++) begin
            e_d = model(cfg_d, t, reset);
            e_s = model(cfg_s, t, reset);
            n_checks += 2;
            if (d_obs !== e_d) begin n_fails++; $display("FAIL frames_default t=%0d got=%h exp=%h", t, d_obs, e_d); end
            if (s_obs !== e_s) begin n_fails++; $display("FAIL frames_small t=%0d got=%h exp=%h", t, s_obs, e_s); end
            if (s_ft) high_cycles++;
            if (s_ft && !prev_ft) pulses++;
            prev_ft = s_ft;
            tick();
        end
`ifdef VGA_FRAME_CNT_EN
        exp_n = 2;
`else
        exp_n = 0;
`endif
        n_checks++;
        if (pulses != exp_n || high_cycles != exp_n) begin
            n_fails++; $display("FAIL frame_ticks got pulses=%0d cycles=%0d exp=%0d", pulses, high_cycles, exp_n);
        end
        n_checks++;
        if (s_fc !== 16'(exp_n)) begin n_fails++; $display("FAIL frame_count got=%0d exp=%0d", s_fc, exp_n); end
    endtask

    task automatic test_mid_frame_reset();
        longint target;
        do_reset();
        target = longint'((7 * S_HT + 20) * S_DIV) + longint'($urandom_range(0, S_DIV - 1));
        while (t < target) begin
            e_s = model(cfg_s, t, reset);
            n_checks++;
            if (s_obs !== e_s) begin n_fails++; $display("FAIL midrun_small t=%0d got=%h exp=%h", t, s_obs, e_s); end
            tick();
        end
        n_checks++;
        if (s_hc !== 10'd20 || s_vc !== 10'd7) begin
            n_fails++; $display("FAIL mid_position got h=%0d v=%0d exp h=20 v=7", s_hc, s_vc);
        end
        reset = 1'b1;
        t     = 0;
        #1;
        n_checks += 2;
        if (s_obs !== '0) begin n_fails++; $display("FAIL mid_reset_small got=%h exp=0", s_obs); end
        if (d_obs !== '0) begin n_fails++; $display("FAIL mid_reset_default got=%h exp=0", d_obs); end
        repeat (2) tick();
        reset = 1'b0;
        for (int k = 0; k < 4 * S_DIV; k++) begin
            e_s = model(cfg_s, t, reset);
            n_checks++;
            if (s_obs !== e_s) begin n_fails++; $display("FAIL mid_release t=%0d got=%h exp=%h", t, s_obs, e_s); end
            tick();
        end
    endtask

    task automatic test_reset_on_tick();
        do_reset();
        while (t < F) tick();
        e_s = model(cfg_s, t, reset);
        n_checks++;
        if (s_obs !== e_s) begin n_fails++; $display("FAIL tick_cycle t=%0d got=%h exp=%h", t, s_obs, e_s); end
        reset = 1'b1;
        t     = 0;
        #1;
        n_checks++;
        if (s_obs !== '0) begin n_fails++; $display("FAIL tick_reset got=%h exp=0", s_obs); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_random_resets();
        int n;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 2 * F + 40);
            do_reset();
            for (int k = 0; k < n; k++) begin
                e_d = model(cfg_d, t, reset);
                e_s = model(cfg_s, t, reset);
                n_checks += 2;
                if (d_obs !== e_d) begin n_fails++; $display("FAIL rand_default t=%0d got=%h exp=%h", t, d_obs, e_d); end
                if (s_obs !== e_s) begin n_fails++; $display("FAIL rand_small t=%0d got=%h exp=%h", t, s_obs, e_s); end
                tick();
            end
            reset = 1'b1;
            t     = 0;
            #1;
            n_checks++;
            if (s_obs !== '0 || d_obs !== '0) begin
                n_fails++; $display("FAIL rand_reset got small=%h default=%h exp=0", s_obs, d_obs);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        t     = 0;
        test_reset();
        test_first_pixels();
        test_line_wrap();
        test_frame();
        test_two_frames();
        test_mid_frame_reset();
        test_reset_on_tick();
        test_random_resets();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 4, system clocks per pixel (100 MHz -> 25 MHz pixel rate).
REQ-002 Parameter H_TOTAL, default 800, pixel periods per line.
REQ-003 Parameter V_TOTAL, default 525, lines per frame.
REQ-004 Parameters H_SYNC=96 and V_SYNC=2 SHALL set the sync pulse widths in pixels and lines.
REQ-005 Parameters H_ACT_START=144, H_ACT_END=783, V_ACT_START=35 and V_ACT_END=514 SHALL set the inclusive visible window.
REQ-006 clk  input  1  system clock; the only clock.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 hCount  output  10  current horizontal pixel position, 0..H_TOTAL-1.
REQ-009 vCount  output  10  current line, 0..V_TOTAL-1.
REQ-010 bright  output  1  high while (hCount,vCount) is inside the visible window.
REQ-011 hSync  output  1  active-low horizontal sync.
REQ-012 vSync  output  1  active-low vertical sync.
REQ-013 pix_en  output  1  one-clk strobe marking each pixel advance.
REQ-014 frame_tick  output  1  one-clk pulse at frame start.
REQ-015 frame_count  output  16  completed-frame counter.

Function
REQ-016 The divider SHALL count 0..CLK_DIV-1; pix_en SHALL be high in exactly the clk cycle in which the divider holds CLK_DIV-1.
REQ-017 On a clk edge with pix_en high, hCount SHALL increment, or wrap H_TOTAL-1 -> 0; with pix_en low, all counters SHALL hold.
REQ-018 vCount SHALL increment only on the edge where hCount wraps; vCount SHALL wrap V_TOTAL-1 -> 0 on that same edge.
REQ-019 hSync SHALL be 0 when hCount < H_SYNC and 1 otherwise; vSync SHALL be 0 when vCount < V_SYNC and 1 otherwise.
REQ-020 bright SHALL be 1 when H_ACT_START<=hCount<=H_ACT_END and V_ACT_START<=vCount<=V_ACT_END, and 0 otherwise.
REQ-021 hSync, vSync and bright SHALL be combinational decodes of hCount and vCount, so they align with the counts in the same cycle (zero latency).
REQ-022 Sync, bright and counter outputs SHALL change only in the cycle following a pix_en edge.
REQ-023 frame_tick SHALL be high for exactly one clk cycle, the first cycle in which hCount=0 and vCount=0 after a wrap from (H_TOTAL-1, V_TOTAL-1).
REQ-024 frame_count SHALL increment on that same wrap edge and SHALL wrap 65535 -> 0.
REQ-025 Counter widths SHALL be fixed at 10 bits; parameter values exceeding 1023 are illegal.

Reset
REQ-026 Asserting reset SHALL immediately set divider=0, hCount=0, vCount=0 and frame_count=0, and force pix_en=0 and frame_tick=0.
REQ-027 During reset, decoded outputs SHALL read hSync=0, vSync=0 and bright=0.
REQ-028 After release, the first pix_en SHALL occur on the CLK_DIV-th clk cycle.
REQ-029 Leaving reset SHALL NOT raise frame_tick.
REQ-030 Reset asserted mid-line or mid-frame SHALL abandon the frame with no partial frame_count increment.

Configuration
REQ-031 With VGA_FRAME_CNT_EN defined, frame_tick and frame_count SHALL behave per REQ-023/024.
REQ-032 Without VGA_FRAME_CNT_EN, both ports SHALL remain present, frame_tick SHALL be tied to 0, frame_count SHALL be tied to 0, and no frame-counter logic SHALL be synthesized.

Structure
REQ-033 Package vga_timing_pkg SHALL hold the default timing constants (H_TOTAL, V_TOTAL, H_SYNC, V_SYNC, the four active-window bounds) and CLK_DIV.
REQ-034 A sub-module vga_mod_counter (mod-N counter with enable input and wrap output) SHALL be instantiated twice, for hCount and vCount.
REQ-035 Window and sync decode SHALL stay in the top module.

Verification
REQ-036 Reset release, 8 clks -> pix_en high on clk 4 and clk 8; hCount=2 after clk 8; vCount=0.
REQ-037 Run 3200 clks -> hCount wraps 799->0 and vCount 0->1 on the same edge; hSync low for exactly 384 clks per line.
REQ-038 Run one full frame (1,680,000 clks) -> vSync low for 6400 clks; bright high for 640x480 pixels; bright=0 at hCount=143 and hCount=784.
REQ-039 Run two full frames with VGA_FRAME_CNT_EN defined -> exactly 2 single-clk frame_tick pulses; frame_count=2.
REQ-040 Assert reset at hCount=400, vCount=300 -> all counts 0 at once; no frame_tick; frame_count unchanged at 0.
REQ-041 Build without VGA_FRAME_CNT_EN, run 2 frames -> frame_tick and frame_count remain 0; REQ-037 timing unchanged.
